// File: rtl/neuron_fp_pkg.sv
// Shared definitions for the 12-bit activation float format and the
// channel tags used on the neuron output path.
package neuron_fp_pkg;

    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 6;
    localparam int FP_BIAS  = 15;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exponent;
        logic [FP_MAN_W-1:0] mantissa;
    } fp12_t;

    typedef enum logic [1:0] {
        CH_TANH    = 2'd0,
        CH_SIGMOID = 2'd1,
        CH_RELU    = 2'd2
    } channel_e;

endpackage

// File: rtl/neuron_output_decoder_if.sv
// Beat-in / fixed-point-out handshake bundle of the neuron output decoder.
// "slave" is the decoder side; "master" is the upstream source plus downstream sink.
interface neuron_output_decoder_if #(
    parameter int OUT_W = 16
);
    import neuron_fp_pkg::*;

    logic                InValid;
    logic                InReady;
    logic                SignIn0;
    logic                SignIn1;
    logic                SignIn2;
    logic [FP_EXP_W-1:0] ExponentIn0;
    logic [FP_EXP_W-1:0] ExponentIn1;
    logic [FP_EXP_W-1:0] ExponentIn2;
    logic [FP_MAN_W-1:0] MantissaIn0;
    logic [FP_MAN_W-1:0] MantissaIn1;
    logic [FP_MAN_W-1:0] MantissaIn2;

    logic                OutValid;
    logic                OutReady;
    logic [OUT_W-1:0]    OutData;
    logic [1:0]          OutChannel;
    logic                OutSat;

    modport slave (
        input  InValid, SignIn0, SignIn1, SignIn2,
               ExponentIn0, ExponentIn1, ExponentIn2,
               MantissaIn0, MantissaIn1, MantissaIn2, OutReady,
        output InReady, OutValid, OutData, OutChannel, OutSat
    );

    modport master (
        output InValid, SignIn0, SignIn1, SignIn2,
               ExponentIn0, ExponentIn1, ExponentIn2,
               MantissaIn0, MantissaIn1, MantissaIn2, OutReady,
        input  InReady, OutValid, OutData, OutChannel, OutSat
    );

endinterface

// File: rtl/fp12_to_fixed.sv
// Combinational 12-bit float to signed fixed-point converter with saturation.
// Right shifts truncate the magnitude, so negative results round toward zero.
module fp12_to_fixed
    import neuron_fp_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8
) (
    input  fp12_t            fpIn,
    output logic [OUT_W-1:0] value,
    output logic             sat
);

    localparam int MAG_W   = FP_MAN_W + 1;
    localparam int MAX_EXP = (1 << FP_EXP_W) - 1;
    localparam int RSH     = FP_BIAS + FP_MAN_W;
    // Wide enough for the largest left shift, so nothing is lost before the limit compare.
    localparam int WIDE_W  = MAG_W + MAX_EXP + FRAC_BITS;
    localparam int SH_W    = $clog2(MAX_EXP + FRAC_BITS + 1);

    localparam logic [WIDE_W-1:0] NEG_LIMIT = WIDE_W'(1) << (OUT_W - 1);
    localparam logic [WIDE_W-1:0] POS_LIMIT = NEG_LIMIT - WIDE_W'(1);

    logic [SH_W-1:0]   shiftAmt;
    logic [WIDE_W-1:0] scaled;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        value    = '0;
        sat      = 1'b0;
        shiftAmt = SH_W'(fpIn.exponent) + SH_W'(FRAC_BITS);
        scaled   = (WIDE_W'({1'b1, fpIn.mantissa}) << shiftAmt) >> RSH;

        if (fpIn.exponent != '0) begin
            if (!fpIn.sign) begin
                if (scaled > POS_LIMIT) begin
                    value = POS_LIMIT[OUT_W-1:0];
                    sat   = 1'b1;
                end else begin
                    value = scaled[OUT_W-1:0];
                end
            end else begin
                if (scaled > NEG_LIMIT) begin
                    value = NEG_LIMIT[OUT_W-1:0];
                    sat   = 1'b1;
                end else begin
                    value = -scaled[OUT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/neuron_output_decoder.sv
// Latches one three-channel activation beat, converts the channels in order
// through a single converter, and queues the results in a fall-through FIFO.
module neuron_output_decoder
    import neuron_fp_pkg::*;
#(
    parameter int OUT_W      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    neuron_output_decoder_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CH0, CH1, CH2} state_e;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [1:0]       channel;
        logic             sat;
    } entry_t;

    state_e           state, stateNext;
    fp12_t [2:0]      latched;
    entry_t           fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;

    fp12_t            convIn;
    logic [OUT_W-1:0] convValue;
    logic             convSat;
    logic [1:0]       curChannel;
    logic             accept, push, pop, pushAllowed;

    fp12_to_fixed #(
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .fpIn  (convIn),
        .value (convValue),
        .sat   (convSat)
    );

    assign bus.OutValid = (count != '0);
    assign pop          = bus.OutValid && bus.OutReady;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pushAllowed  = (count != (PTR_W+1)'(FIFO_DEPTH)) || pop;

    always_comb begin
        stateNext   = state;
        bus.InReady = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        convIn      = latched[0];
        curChannel  = CH_TANH;

        unique case (state)
            IDLE: begin
                bus.InReady = 1'b1;
                if (bus.InValid) begin
                    accept    = 1'b1;
                    stateNext = CH0;
                end
            end
            CH0: begin
                push = pushAllowed;
                if (pushAllowed) stateNext = CH1;
            end
            CH1: begin
                convIn     = latched[1];
                curChannel = CH_SIGMOID;
                push       = pushAllowed;
                if (pushAllowed) stateNext = CH2;
            end
            CH2: begin
                convIn     = latched[2];
                curChannel = CH_RELU;
                push       = pushAllowed;
                if (pushAllowed) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= IDLE;
            latched <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                latched[0] <= '{sign: bus.SignIn0, exponent: bus.ExponentIn0, mantissa: bus.MantissaIn0};
                latched[1] <= '{sign: bus.SignIn1, exponent: bus.ExponentIn1, mantissa: bus.MantissaIn1};
                latched[2] <= '{sign: bus.SignIn2, exponent: bus.ExponentIn2, mantissa: bus.MantissaIn2};
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers decide which entries are visible.
    always_ff @(posedge Clock) begin
        if (push) fifoMem[wrPtr] <= '{data: convValue, channel: curChannel, sat: convSat};
    end

    assign bus.OutData    = bus.OutValid ? fifoMem[rdPtr].data    : '0;
    assign bus.OutChannel = bus.OutValid ? fifoMem[rdPtr].channel : 2'd0;
    assign bus.OutSat     = bus.OutValid ? fifoMem[rdPtr].sat     : 1'b0;

endmodule
